// File: rtl/step_chart_sequencer.sv
// step_chart_sequencer: plays a writable step chart of {last, lane, gap}
// entries, counting video frames and pulsing launch_o with a lane index.
// Optional feature macro: STEP_CHART_LOOP_EN -- when defined the chart
// repeats forever instead of stopping in DONE.
module step_chart_sequencer #(
  parameter int CHART_DEPTH = 64,
  parameter int ADDR_W      = 6,
  parameter int GAP_W       = 8,
  parameter int MIN_GAP     = 25
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              frame_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [GAP_W+2:0]  wr_data_i,
  output logic              launch_o,
  output logic [1:0]        lane_o,
  output logic [ADDR_W-1:0] index_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LAUNCH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        ent_lane_q, ent_lane_d;
  logic              ent_last_q, ent_last_d;

  logic [GAP_W+2:0]  mem [CHART_DEPTH];
  logic [GAP_W+2:0]  rd_data_q;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  eff_wait;

  // Chart RAM: the read address is the next index, so the entry for the
  // index being entered is on rd_data_q during FETCH. Same-address
  // read/write returns old data.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem[index_d];
  end

  // Short gaps are stretched so an arrow slot always finishes its flight.
  always_comb begin
    gap      = rd_data_q[GAP_W-1:0];
    eff_wait = (gap < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap;
  end

  // Next-state and datapath updates for the playback FSM.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    ent_lane_d = ent_lane_q;
    ent_last_d = ent_last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_FETCH;
          index_d = '0;
        end
      end
      S_FETCH: begin
        ent_lane_d = rd_data_q[GAP_W+1:GAP_W];
        ent_last_d = rd_data_q[GAP_W+2];
        cnt_d      = eff_wait;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (frame_i && !pause_i) begin
          cnt_d = cnt_q - GAP_W'(1);
          if (cnt_q == GAP_W'(1)) begin
            state_d = S_LAUNCH;
            lane_d  = ent_lane_q;  // lane is visible in the launch cycle
          end
        end
      end
      S_LAUNCH: begin
        if (ent_last_q || index_q == ADDR_W'(CHART_DEPTH - 1)) begin
`ifdef STEP_CHART_LOOP_EN
          index_d = '0;
          state_d = S_FETCH;
`else
          state_d = S_DONE;
`endif
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; chart RAM is deliberately not reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      ent_lane_q <= '0;
      ent_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      ent_lane_q <= ent_lane_d;
      ent_last_q <= ent_last_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    launch_o = (state_q == S_LAUNCH);
    busy_o   = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_LAUNCH);
    done_o   = (state_q == S_DONE);
    lane_o   = lane_q;
    index_o  = index_q;
  end

endmodule

// File: tb/tb_step_chart_sequencer.sv
// Scoreboard bench for step_chart_sequencer: stimulus pushes the expected
// launch (lane, index, cycle) when it issues the expiring frame strobe; a
// negedge monitor pops and compares on every launch_o pulse.
module tb_step_chart_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0, start = 1'b0, pause = 1'b0, wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [10:0] wr_data = '0;
  logic        launch, busy, done;
  logic [1:0]  lane;
  logic [5:0]  index;

  always #5 clk = ~clk;

  step_chart_sequencer #(.CHART_DEPTH(64), .ADDR_W(6), .GAP_W(8), .MIN_GAP(25)) dut (
    .clk_i(clk), .reset_ni(rst_n), .frame_i(frame), .start_i(start), .pause_i(pause),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .launch_o(launch), .lane_o(lane), .index_o(index), .busy_o(busy), .done_o(done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    int lane;
    int idx;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic prev_launch = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every launch pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (launch) begin
      check("launch_not_back_to_back", int'(prev_launch), 0);
      if (q.size() == 0) begin
        check("unexpected_launch_cycle", cyc, -1);
      end else begin
        mon_e = q.pop_front();
        check("launch_lane", int'(lane), mon_e.lane);
        check("launch_index", int'(index), mon_e.idx);
        check("launch_cycle", cyc, mon_e.cyc);
      end
    end
    prev_launch = launch;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int last, input int ln, input int gap);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = {1'(last), 2'(ln), 8'(gap)};
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // start sampled at cycle 0, FETCH in cycle 1, WAIT from cycle 2.
  task automatic start_play();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_busy", int'(busy), 1);
    tick();
    check("wait_busy", int'(busy), 1);
  endtask

  // n strobes spaced 10 cycles apart, strobes plo..phi issued with pause
  // high; the nth strobe is expected to fire a launch one cycle later.
  // st_at pulses start during WAIT after that strobe.
  task automatic play(input int n, input int ln, input int idx,
                      input int plo = 0, input int phi = -1, input int st_at = -1);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      pause = (i >= plo && i <= phi);
      frame = 1'b1;
      if (i == n) begin
        e.lane = ln; e.idx = idx; e.cyc = cyc + 1;
        q.push_back(e);
      end
      tick();
      frame = 1'b0;
      if (i == st_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_index", int'(index), idx);
        check("busy_start_still_busy", int'(busy), 1);
        repeat (8) tick();
      end else begin
        repeat (9) tick();
      end
    end
    pause = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      repeat (9) tick();
    end
  endtask

  task automatic reset_if_loop();
`ifdef STEP_CHART_LOOP_EN
    do_reset();
`endif
  endtask

  task automatic check_done(input string tag);
`ifndef STEP_CHART_LOOP_EN
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy"}, int'(busy), 0);
`endif
  endtask

  initial begin
    // Reset values
    tick();
    check("rst_launch", int'(launch), 0);
    check("rst_lane", int'(lane), 0);
    check("rst_index", int'(index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();
    strobes(2);  // frames in IDLE are ignored
    check("idle_busy", int'(busy), 0);

    // Basic sequence
    wr(0, 0, 2, 30);
    wr(1, 1, 1, 40);
    start_play();
    play(30, 2, 0);
    play(40, 1, 1);
    check_done("basic");

    // Gap clamp: gap 0 waits MIN_GAP frames; restarts from DONE
    wr(0, 1, 3, 0);
    reset_if_loop();
    start_play();
    play(25, 3, 0);
    check_done("clamp");

    // Pause over strobes 6..15: 30 counted of 40 total
    wr(0, 1, 0, 30);
    reset_if_loop();
    start_play();
    play(40, 0, 0, 6, 15);
    check_done("pause");

    // Start while busy is ignored
    wr(0, 0, 2, 25);
    wr(1, 1, 3, 26);
    reset_if_loop();
    start_play();
    play(25, 2, 0);
    play(26, 3, 1, 0, -1, 10);
    check_done("busystart");

    // Reset mid-WAIT at entry 3, chart preserved across reset
    wr(0, 0, 2, 25);
    wr(1, 0, 1, 25);
    wr(2, 0, 3, 25);
    wr(3, 1, 0, 25);
    reset_if_loop();
    start_play();
    play(25, 2, 0);
    play(25, 1, 1);
    play(25, 3, 2);
    strobes(10);
    check("pre_reset_index", int'(index), 3);
    check("pre_reset_lane", int'(lane), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_launch", int'(launch), 0);
    check("mid_rst_lane", int'(lane), 0);
    check("mid_rst_index", int'(index), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_play();
    play(25, 2, 0);
    play(25, 1, 1);
    do_reset();

    // Depth wrap: 64 entries, none marked last
    for (int a = 0; a < 64; a++) wr(a, 0, a % 4, 25);
    start_play();
    for (int k = 0; k < 64; k++) play(25, k % 4, k);
`ifdef STEP_CHART_LOOP_EN
    play(25, 0, 0);
    check("wrap_done", int'(done), 0);
    check("wrap_busy", int'(busy), 1);
`else
    check("wrap_done", int'(done), 1);
    check("wrap_busy", int'(busy), 0);
    check("wrap_index", int'(index), 63);
`endif

    repeat (5) tick();
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/step_chart_sequencer.md
# step_chart_sequencer

- Drives the launch interface of the arrow movement block.
- Holds a writable step chart: a list of `{last, lane, gap}` entries.
- Counts video frames and issues one-cycle `launch_o` pulses with a lane index, spaced so each arrow slot finishes its flight before it is reused.
- Sits between the song/chart loader and the arrow movement/rendering blocks.

## Interface

Parameters:
- `CHART_DEPTH`, 64 — number of chart entries.
- `ADDR_W`, 6 — chart address width; equals log2(`CHART_DEPTH`).
- `GAP_W`, 8 — width of the per-entry frame gap field.
- `MIN_GAP`, 25 — minimum frames between launches; must be ≥1 and <2^`GAP_W`.

Ports:
- Clock and reset (one clock; reset is asynchronous, active-low):
  - `clk_i` input 1 — system clock.
  - `reset_ni` input 1 — asynchronous active-low reset.
- Control:
  - `frame_i` input 1 — one-cycle strobe per video frame.
  - `start_i` input 1 — begin playback at entry 0.
  - `pause_i` input 1 — while high, `frame_i` strobes are not counted.
- Chart write port:
  - `wr_en_i` input 1 — chart write enable.
  - `wr_addr_i` input `ADDR_W` — chart write address.
  - `wr_data_i` input `GAP_W+3` — entry fields:
    - bit `GAP_W+2` = last.
    - bits `GAP_W+1:GAP_W` = lane.
    - bits `GAP_W-1:0` = gap.
- Outputs:
  - `launch_o` output 1 — one-cycle launch pulse.
  - `lane_o` output 2 — lane of the current or last launch; held between launches.
  - `index_o` output `ADDR_W` — address of the entry being played.
  - `busy_o` output 1 — high in FETCH, WAIT and LAUNCH.
  - `done_o` output 1 — high in DONE.

## Operation

- Chart storage is `CHART_DEPTH` × (`GAP_W`+3) synchronous-read RAM.
  - Contents are not reset.
  - Writes are accepted in every state.
  - A read and a write to the same address in the same cycle return the old data.
- Effective wait = `MIN_GAP` if gap < `MIN_GAP`, else gap. gap=0 therefore waits `MIN_GAP` frames.
- States (encoding free):
  - IDLE:
    - `start_i` → FETCH, `index_o`←0.
  - FETCH (1 cycle):
    - Latch the RAM entry.
    - Load the frame counter with the effective wait.
    - → WAIT.
  - WAIT:
    - On `frame_i` & !`pause_i`, decrement the counter.
    - When a qualifying strobe arrives with counter==1 → LAUNCH.
  - LAUNCH (1 cycle):
    - `launch_o`=1; `lane_o`←entry lane.
    - If entry last==1 or `index_o`==`CHART_DEPTH`-1 → DONE.
    - Otherwise `index_o`++ → FETCH.
  - DONE:
    - `done_o`=1.
    - `start_i` → FETCH, `index_o`←0.
- `start_i` in FETCH, WAIT or LAUNCH is ignored; no restart mid-song.
- `frame_i` outside WAIT is ignored.
- `pause_i` only masks counting; the state and counter are held.
- Counter width is `GAP_W`, and the counter never underflows because the loaded value is ≥1.

## Timing

- Reset values:
  - State = IDLE.
  - `launch_o`=0, `lane_o`=0, `index_o`=0, `busy_o`=0, `done_o`=0.
  - Counter = 0.
- Every output is registered, i.e. decoded from registered state.
- Start latency:
  - `start_i` sampled at cycle 0.
  - FETCH in cycle 1.
  - WAIT from cycle 2.
- Launch latency: `launch_o` is high exactly in the cycle after the expiring `frame_i` strobe.
- Between consecutive launches there is exactly the effective-wait count of qualifying strobes.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous). Chart contents are preserved.
- `launch_o` is never high on two consecutive cycles.

## Configuration

- `STEP_CHART_LOOP_EN`
  - Defined: in LAUNCH, the last entry or `CHART_DEPTH`-1 wraps `index_o` to 0 and → FETCH.
    - The song repeats forever.
    - DONE is unreachable and `done_o` stays 0.
    - Only reset stops playback.
  - Undefined: behaviour as specified in Operation. Playback stops in DONE.

## Test plan

- Basic sequence:
  - Stimulus:
    - Write entry0 = {0,2,30} and entry1 = {1,1,40}.
    - Pulse `start_i`.
    - Drive `frame_i` every 10 cycles.
  - Response:
    - `launch_o` with `lane_o`=2 one cycle after the 30th strobe.
    - `launch_o` with `lane_o`=1 one cycle after the next 40 strobes.
    - Then `done_o`=1 and `busy_o`=0.
- Gap clamp:
  - Stimulus: entry0 = {1,3,0}.
  - Response: launch one cycle after the 25th strobe, `lane_o`=3.
- Pause:
  - Stimulus:
    - entry0 gap = 30.
    - Hold `pause_i` high across 10 strobes after the 5th counted strobe.
  - Response: launch after 30 counted strobes, i.e. 40 total.
- Start while busy:
  - Stimulus: pulse `start_i` during WAIT.
  - Response: `index_o` is unchanged and the launch timing is unchanged.
- Reset mid-WAIT:
  - Stimulus:
    - Drop `reset_ni` during WAIT at entry 3.
    - Release, then start again.
  - Response:
    - Outputs are 0 during reset.
    - After restart, replay from entry 0 using the preserved chart.
- Depth wrap:
  - Stimulus: fill all 64 entries with last=0, gap=25.
  - Response:
    - Without `STEP_CHART_LOOP_EN`: DONE after the 64th launch.
    - With `STEP_CHART_LOOP_EN`: the 65th launch reads entry 0 and `done_o` stays 0.
